cmd_frame_issuer: RTL and testbench
===================================

Name: cmd_frame_issuer

Overview:
Host-side initiator for the system's UART command protocol; it drives the command-decoding controller from the other end. It accepts one abstract command, serializes its byte frame (0xAA/0xBB/0xCC/0xDD + payload) into the UART TX byte interface, then collects the response bytes from UART RX. Used in the host bridge and loopback test harness.

Parameters:
RSP_TIMEOUT, 1024, cycles to wait for first response byte before flagging timeout
HI_WINDOW, 64, cycles after first ALU response byte to wait for optional high byte

Ports:
CLK  in  1  system clock
RST  in  1  async active-low reset
CMD_VLD  in  1  command request; sampled only when CMD_RDY=1
CMD_TYPE  in  2  0=REG_WR, 1=REG_RD, 2=ALU_OP (with operands), 3=ALU_NOP
CMD_ADDR  in  4  register address (REG_WR/REG_RD)
CMD_DATA  in  8  write data (REG_WR) / operand A (ALU_OP)
CMD_OPB  in  8  operand B (ALU_OP)
CMD_FUN  in  4  ALU function (ALU_OP/ALU_NOP)
CMD_RDY  out  1  high only in IDLE
TX_P_DATA  out  8  frame byte to UART TX
TX_D_VLD  out  1  byte valid; held with stable data until TX_RDY
TX_RDY  in  1  UART TX accepts byte when TX_D_VLD&TX_RDY
RX_P_Data  in  8  response byte from UART RX
RX_D_VLD  in  1  one-cycle strobe per received byte
RSP_DATA  out  16  collected response; held until next command accepted
RSP_VLD  out  1  one-cycle pulse at command completion
RSP_TMO  out  1  one-cycle pulse with RSP_VLD when response timed out

Behaviour:
- Reset: state IDLE; CMD_RDY=1; TX_P_DATA=0, TX_D_VLD=0, RSP_DATA=0, RSP_VLD=0, RSP_TMO=0; counters cleared. Reset mid-frame aborts silently; no partial-frame recovery.
- Accept: CMD_VLD&CMD_RDY registers all CMD_* fields; CMD_RDY drops the next cycle. CMD_VLD outside IDLE ignored.
- Frames (byte order): REG_WR: AA, {4'h0,ADDR}, DATA. REG_RD: BB, {4'h0,ADDR}. ALU_OP: CC, DATA, OPB, {4'h0,FUN}. ALU_NOP: DD, {4'h0,FUN}.
- States: IDLE -> SEND -> (WAIT_RSP -> [WAIT_HI]) -> DONE -> IDLE.
- SEND: byte index counter 0..len-1; TX_D_VLD=1 from the cycle after accept; index advances on TX_D_VLD&TX_RDY; TX_P_DATA changes only on handshake. Back-to-back acceptance allowed (one byte/cycle if TX_RDY stays high). After last handshake: REG_WR -> DONE (no response, RSP_DATA=0); others -> WAIT_RSP.
- WAIT_RSP: timeout counter cleared on entry, increments each cycle. RX_D_VLD: RSP_DATA={8'h00,RX_P_Data}; REG_RD -> DONE; ALU_OP/ALU_NOP -> WAIT_HI. Counter reaching RSP_TIMEOUT-1 without byte -> DONE with RSP_TMO, RSP_DATA=0. RX_D_VLD on that same cycle wins (no timeout).
- WAIT_HI: RX_D_VLD within HI_WINDOW cycles -> RSP_DATA[15:8]=RX_P_Data, DONE; window expiry -> DONE keeping high byte 0 (not a timeout).
- RX_D_VLD in IDLE/SEND/DONE ignored (stray bytes dropped).
- DONE: one cycle; RSP_VLD=1 (RSP_TMO as set); next cycle IDLE, CMD_RDY=1. Minimum REG_RD latency from accept with TX_RDY=1 and immediate response: 2 send cycles + response.
- Counter widths $clog2 of respective parameter; no wrap beyond terminal count.

Decomposition:
- Shared package: command type codes (REG_WR..ALU_NOP), opcode bytes 8'hAA/8'hBB/8'hCC/8'hDD, frame lengths 3/2/4/2, state encodings.
- One sub-module natural: frame_byte_mux (combinational byte select from type+index+registered fields); FSM, counters and response capture stay in top.

Test Plan:
- REG_WR addr=5 data=0x3C, TX_RDY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; RSP_VLD pulse, RSP_DATA=0x0000, RSP_TMO=0.
- REG_RD addr=2, TX_RDY toggling 1/0 -> bytes BB,02 held stable during stalls; inject RX 0x7E -> RSP_DATA=0x007E, RSP_VLD.
- ALU_OP A=0x10 B=0x20 FUN=2 -> CC,10,20,02; RX 0x00 then 0x02 within window -> RSP_DATA=0x0200.
- ALU_NOP FUN=8, single RX 0x01, no second byte -> RSP_DATA=0x0001 after HI_WINDOW cycles, RSP_TMO=0.
- REG_RD with no RX -> RSP_VLD+RSP_TMO exactly RSP_TIMEOUT cycles after last TX handshake; RX on terminal cycle -> no timeout.
- Assert RST mid-SEND of ALU_OP -> outputs at reset values immediately, CMD_RDY=1; new REG_RD completes normally; CMD_VLD pulsed while busy -> ignored.

Source files
------------

// File: rtl/cmd_frame_issuer_pkg.sv
// Shared types and constants for the host-side UART command frame issuer.
package cmd_frame_issuer_pkg;

    typedef enum logic [1:0] {
        CMD_REG_WR  = 2'd0,
        CMD_REG_RD  = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    localparam logic [7:0] OP_REG_WR  = 8'hAA;
    localparam logic [7:0] OP_REG_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    localparam int LEN_REG_WR  = 3;
    localparam int LEN_REG_RD  = 2;
    localparam int LEN_ALU_OP  = 4;
    localparam int LEN_ALU_NOP = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_WAIT_HI,
        ST_DONE
    } state_e;

    typedef struct packed {
        cmd_type_e  typ;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] opb;
        logic [3:0] fun;
    } cmd_t;

    // Index of the final byte of a frame.
    function automatic logic [1:0] frame_last(input cmd_type_e t);
        logic [1:0] last;
        unique case (t)
            CMD_REG_WR:  last = 2'(LEN_REG_WR - 1);
            CMD_REG_RD:  last = 2'(LEN_REG_RD - 1);
            CMD_ALU_OP:  last = 2'(LEN_ALU_OP - 1);
            CMD_ALU_NOP: last = 2'(LEN_ALU_NOP - 1);
        endcase
        return last;
    endfunction

endpackage

// File: rtl/cmd_frame_issuer_frame_byte_mux.sv
// Combinational selection of one frame byte from command type and index.
module cmd_frame_issuer_frame_byte_mux
    import cmd_frame_issuer_pkg::*;
(
    input  cmd_t       cmd,
    input  logic [1:0] idx,
    output logic [7:0] frame_byte
);

    always_comb begin
        frame_byte = 8'h00;
        unique case (cmd.typ)
            CMD_REG_WR: begin
                case (idx)
                    2'd0:    frame_byte = OP_REG_WR;
                    2'd1:    frame_byte = {4'h0, cmd.addr};
                    2'd2:    frame_byte = cmd.data;
                    default: frame_byte = 8'h00;
                endcase
            end
            CMD_REG_RD: begin
                case (idx)
                    2'd0:    frame_byte = OP_REG_RD;
                    2'd1:    frame_byte = {4'h0, cmd.addr};
                    default: frame_byte = 8'h00;
                endcase
            end
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    frame_byte = OP_ALU_OP;
                    2'd1:    frame_byte = cmd.data;
                    2'd2:    frame_byte = cmd.opb;
                    default: frame_byte = {4'h0, cmd.fun};
                endcase
            end
            CMD_ALU_NOP: begin
                case (idx)
                    2'd0:    frame_byte = OP_ALU_NOP;
                    2'd1:    frame_byte = {4'h0, cmd.fun};
                    default: frame_byte = 8'h00;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/cmd_frame_issuer.sv
// Host-side command initiator: serializes one command frame to UART TX
// and collects the response bytes from UART RX.
module cmd_frame_issuer
    import cmd_frame_issuer_pkg::*;
#(
    parameter int RSP_TIMEOUT = 1024,
    parameter int HI_WINDOW   = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VLD,
    input  logic [1:0]  CMD_TYPE,
    input  logic [3:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA,
    input  logic [7:0]  CMD_OPB,
    input  logic [3:0]  CMD_FUN,
    output logic        CMD_RDY,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_RDY,
    input  logic [7:0]  RX_P_Data,
    input  logic        RX_D_VLD,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VLD,
    output logic        RSP_TMO
);

    localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam int HW = (HI_WINDOW > 1) ? $clog2(HI_WINDOW) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);
    localparam logic [HW-1:0] HI_LAST  = HW'(HI_WINDOW - 1);

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d, cmd_in, mux_cmd;
    logic [1:0]    idx_q, idx_d, mux_idx;
    logic [7:0]    tx_data_q, tx_data_d, mux_byte;
    logic          tx_vld_q, tx_vld_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic          rsp_tmo_q, rsp_tmo_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [HW-1:0] hi_cnt_q, hi_cnt_d;
    logic          tx_hs;

    assign cmd_in = '{typ:  cmd_type_e'(CMD_TYPE),
                      addr: CMD_ADDR,
                      data: CMD_DATA,
                      opb:  CMD_OPB,
                      fun:  CMD_FUN};

    assign tx_hs = tx_vld_q & TX_RDY;

    // The mux looks one byte ahead so TX_P_DATA is registered on handshake.
    cmd_frame_issuer_frame_byte_mux u_mux (
        .cmd        (mux_cmd),
        .idx        (mux_idx),
        .frame_byte (mux_byte)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = tx_vld_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = 1'b0;
        rsp_tmo_d  = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        mux_cmd    = cmd_q;
        mux_idx    = 2'(idx_q + 2'd1);
        unique case (state_q)
            ST_IDLE: begin
                if (CMD_VLD) begin
                    cmd_d      = cmd_in;
                    mux_cmd    = cmd_in;
                    mux_idx    = 2'd0;
                    idx_d      = 2'd0;
                    tx_data_d  = mux_byte;
                    tx_vld_d   = 1'b1;
                    rsp_data_d = 16'h0000;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_hs) begin
                    if (idx_q == frame_last(cmd_q.typ)) begin
                        tx_vld_d  = 1'b0;
                        tmo_cnt_d = '0;
                        if (cmd_q.typ == CMD_REG_WR) begin
                            state_d   = ST_DONE;
                            rsp_vld_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_RSP;
                        end
                    end else begin
                        idx_d     = 2'(idx_q + 2'd1);
                        tx_data_d = mux_byte;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (RX_D_VLD) begin
                    rsp_data_d = {8'h00, RX_P_Data};
                    if (cmd_q.typ == CMD_REG_RD) begin
                        state_d   = ST_DONE;
                        rsp_vld_d = 1'b1;
                    end else begin
                        state_d  = ST_WAIT_HI;
                        hi_cnt_d = '0;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = ST_DONE;
                    rsp_vld_d  = 1'b1;
                    rsp_tmo_d  = 1'b1;
                    rsp_data_d = 16'h0000;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (RX_D_VLD) begin
                    rsp_data_d[15:8] = RX_P_Data;
                    state_d          = ST_DONE;
                    rsp_vld_d        = 1'b1;
                end else if (hi_cnt_q == HI_LAST) begin
                    state_d   = ST_DONE;
                    rsp_vld_d = 1'b1;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            idx_q      <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_vld_q   <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_vld_q  <= 1'b0;
            rsp_tmo_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            hi_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_tmo_q  <= rsp_tmo_d;
            tmo_cnt_q  <= tmo_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
        end
    end

    assign CMD_RDY   = (state_q == ST_IDLE);
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_VLD   = rsp_vld_q;
    assign RSP_TMO   = rsp_tmo_q;

endmodule

// File: tb/tb_cmd_frame_issuer.sv
// Directed-vector bench for cmd_frame_issuer: frame bytes, response
// capture, timeouts, high-byte window, reset abort and busy behaviour.
module tb_cmd_frame_issuer;

    localparam int RSP_TIMEOUT = 1024;
    localparam int HI_WINDOW   = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VLD = 1'b0;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [3:0]  CMD_ADDR = 4'd0;
    logic [7:0]  CMD_DATA = 8'd0;
    logic [7:0]  CMD_OPB = 8'd0;
    logic [3:0]  CMD_FUN = 4'd0;
    logic        CMD_RDY;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_RDY = 1'b1;
    logic [7:0]  RX_P_Data = 8'd0;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_TMO;

    cmd_frame_issuer #(
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .HI_WINDOW   (HI_WINDOW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VLD   (CMD_VLD),
        .CMD_TYPE  (CMD_TYPE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .CMD_OPB   (CMD_OPB),
        .CMD_FUN   (CMD_FUN),
        .CMD_RDY   (CMD_RDY),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .TX_RDY    (TX_RDY),
        .RX_P_Data (RX_P_Data),
        .RX_D_VLD  (RX_D_VLD),
        .RSP_DATA  (RSP_DATA),
        .RSP_VLD   (RSP_VLD),
        .RSP_TMO   (RSP_TMO)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]      typ;
        logic [3:0]      addr;
        logic [7:0]      data;
        logic [7:0]      opb;
        logic [3:0]      fun;
        bit              stall;
        bit              poke;
        int              len;
        logic [3:0][7:0] bytes;
        int              rx_cnt;
        logic [1:0][7:0] rx;
        int              gap0;
        int              gap1;
        int              lat;
        logic [15:0]     rsp;
        bit              tmo;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] typ, input logic [3:0] addr,
        input logic [7:0] data, input logic [7:0] opb,
        input logic [3:0] fun, input bit stall, input bit poke,
        input int len, input logic [7:0] b0, input logic [7:0] b1,
        input logic [7:0] b2, input logic [7:0] b3,
        input int rx_cnt, input logic [7:0] r0, input logic [7:0] r1,
        input int gap0, input int gap1, input int lat,
        input logic [15:0] rsp, input bit tmo);
        vec_t v;
        v.typ = typ; v.addr = addr; v.data = data; v.opb = opb;
        v.fun = fun; v.stall = stall; v.poke = poke; v.len = len;
        v.bytes[0] = b0; v.bytes[1] = b1;
        v.bytes[2] = b2; v.bytes[3] = b3;
        v.rx_cnt = rx_cnt; v.rx[0] = r0; v.rx[1] = r1;
        v.gap0 = gap0; v.gap1 = gap1; v.lat = lat;
        v.rsp = rsp; v.tmo = tmo;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Latency is counted in edges from the final TX handshake edge.
    task automatic do_cmd(input vec_t v, input string tag);
        int n;
        int k;
        int lat;
        int ri;
        int gapc;
        int gap;
        bit stalled;
        logic [7:0] held;
        n = 0;
        while (!CMD_RDY && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_rdy_idle"}, CMD_RDY, 1);
        CMD_VLD = 1'b1; CMD_TYPE = v.typ; CMD_ADDR = v.addr;
        CMD_DATA = v.data; CMD_OPB = v.opb; CMD_FUN = v.fun;
        tick();
        CMD_VLD = 1'b0;
        chk({tag, "_rdy_drop"}, CMD_RDY, 0);
        chk({tag, "_txvld_start"}, TX_D_VLD, 1);
        k = 0; n = 0; stalled = 0; held = 8'h00;
        while (k < v.len && n < 200) begin
            if (v.poke) begin
                CMD_VLD  = (n == 0);
                CMD_TYPE = 2'd0;
                CMD_ADDR = 4'hE;
            end
            if (stalled) chk({tag, "_tx_hold"}, TX_P_DATA, held);
            TX_RDY = v.stall ? (n % 2 == 1) : 1'b1;
            if (TX_D_VLD && TX_RDY) begin
                chk($sformatf("%s_txbyte%0d", tag, k), TX_P_DATA,
                    v.bytes[k]);
                k++;
                stalled = 0;
            end else begin
                stalled = TX_D_VLD;
                held = TX_P_DATA;
            end
            tick();
            n++;
        end
        CMD_VLD = 1'b0;
        TX_RDY = 1'b1;
        chk({tag, "_tx_count"}, k, v.len);
        if (!v.stall) chk({tag, "_tx_cycles"}, n, v.len);
        chk({tag, "_txvld_end"}, TX_D_VLD, 0);
        lat = 0; ri = 0; gapc = 0;
        while (!RSP_VLD && lat < 2000) begin
            gap = (ri == 0) ? v.gap0 : v.gap1;
            if (ri < v.rx_cnt && gapc == gap) begin
                RX_D_VLD = 1'b1;
                RX_P_Data = v.rx[ri];
                ri++;
                gapc = 0;
            end else begin
                RX_D_VLD = 1'b0;
                gapc++;
            end
            tick();
            lat++;
        end
        RX_D_VLD = 1'b0;
        chk({tag, "_rsp_vld"}, RSP_VLD, 1);
        if (v.lat >= 0) chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_rsp_data"}, RSP_DATA, v.rsp);
        chk({tag, "_rsp_tmo"}, RSP_TMO, v.tmo);
        tick();
        chk({tag, "_vld_pulse"}, RSP_VLD, 0);
        chk({tag, "_tmo_pulse"}, RSP_TMO, 0);
        chk({tag, "_rdy_back"}, CMD_RDY, 1);
        chk({tag, "_rsp_hold"}, RSP_DATA, v.rsp);
    endtask

    vec_t vecs[8];
    vec_t post;
    bit seen;

    initial begin
        vecs[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 0, 0, 3,
                     8'hAA, 8'h05, 8'h3C, 8'h00, 0, 8'h00, 8'h00,
                     0, 0, 0, 16'h0000, 0);
        vecs[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1, 0, 2,
                     8'hBB, 8'h02, 8'h00, 8'h00, 1, 8'h7E, 8'h00,
                     0, 0, 1, 16'h007E, 0);
        vecs[2] = mk(2'd2, 4'h0, 8'h10, 8'h20, 4'h2, 0, 0, 4,
                     8'hCC, 8'h10, 8'h20, 8'h02, 2, 8'h00, 8'h02,
                     0, 3, 5, 16'h0200, 0);
        vecs[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 4'h8, 0, 0, 2,
                     8'hDD, 8'h08, 8'h00, 8'h00, 1, 8'h01, 8'h00,
                     0, 0, 1 + HI_WINDOW, 16'h0001, 0);
        vecs[4] = mk(2'd1, 4'h9, 8'h00, 8'h00, 4'h0, 0, 0, 2,
                     8'hBB, 8'h09, 8'h00, 8'h00, 0, 8'h00, 8'h00,
                     0, 0, RSP_TIMEOUT, 16'h0000, 1);
        vecs[5] = mk(2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 0, 0, 2,
                     8'hBB, 8'h03, 8'h00, 8'h00, 1, 8'hA5, 8'h00,
                     RSP_TIMEOUT - 1, 0, RSP_TIMEOUT, 16'h00A5, 0);
        vecs[6] = mk(2'd3, 4'h0, 8'h00, 8'h00, 4'hF, 0, 0, 2,
                     8'hDD, 8'h0F, 8'h00, 8'h00, 2, 8'h34, 8'h12,
                     0, HI_WINDOW - 1, 1 + HI_WINDOW, 16'h1234, 0);
        vecs[7] = mk(2'd0, 4'hF, 8'hFF, 8'h00, 4'h0, 1, 0, 3,
                     8'hAA, 8'h0F, 8'hFF, 8'h00, 0, 8'h00, 8'h00,
                     0, 0, 0, 16'h0000, 0);
        post = mk(2'd1, 4'h4, 8'h00, 8'h00, 4'h0, 1, 1, 2,
                  8'hBB, 8'h04, 8'h00, 8'h00, 1, 8'hC3, 8'h00,
                  2, 0, 3, 16'h00C3, 0);

        repeat (3) @(posedge CLK);
        #3;
        RST = 1'b1;
        tick();
        chk("rst_cmd_rdy", CMD_RDY, 1);
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_tx_data", TX_P_DATA, 0);
        chk("rst_rsp", {RSP_VLD, RSP_TMO, RSP_DATA}, 0);

        for (int i = 0; i < 8; i++) begin
            do_cmd(vecs[i], $sformatf("v%0d", i));
        end

        // Abort an ALU_OP frame after its first byte.
        CMD_VLD = 1'b1; CMD_TYPE = 2'd2; CMD_DATA = 8'h10;
        CMD_OPB = 8'h20; CMD_FUN = 4'h2; TX_RDY = 1'b1;
        tick();
        CMD_VLD = 1'b0;
        tick();
        chk("mid_tx_data", TX_P_DATA, 8'h10);
        RST = 1'b0;
        #1;
        chk("abort_cmd_rdy", CMD_RDY, 1);
        chk("abort_tx_vld", TX_D_VLD, 0);
        chk("abort_tx_data", TX_P_DATA, 0);
        chk("abort_rsp", {RSP_VLD, RSP_TMO, RSP_DATA}, 0);
        #2;
        RST = 1'b1;
        tick();

        seen = 0;
        for (int i = 0; i < 3; i++) begin
            RX_D_VLD = 1'b1;
            RX_P_Data = 8'h55;
            tick();
            seen |= RSP_VLD;
        end
        RX_D_VLD = 1'b0;
        tick();
        seen |= RSP_VLD;
        chk("stray_rx_idle", seen, 0);
        chk("stray_rx_rdy", CMD_RDY, 1);

        do_cmd(post, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
